// File: rtl/riscv_imem_pkg.sv
// Shared types and constants for the RI5CY instruction-memory responder.
package riscv_imem_pkg;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback bits 7,5,4,3 give x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned MEM_LATENCY_MIN     = 1;
  localparam int unsigned MEM_LATENCY_MAX     = 4;
  localparam int unsigned MAX_OUTSTANDING_MIN = 1;
  localparam int unsigned MAX_OUTSTANDING_MAX = 4;

  typedef struct packed {
    logic valid;
    logic err;
  } imem_rsp_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] state);
    return {state[6:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/riscv_instr_mem_responder_if.sv
// RI5CY instruction fetch port; signal suffixes are as seen from the responder.
interface riscv_instr_mem_responder_if #(
  parameter int unsigned RDATA_WIDTH = 32
);
  logic                   instr_req_i;
  logic [31:0]            instr_addr_i;
  logic                   instr_gnt_o;
  logic                   instr_rvalid_o;
  logic [RDATA_WIDTH-1:0] instr_rdata_o;
  logic                   instr_err_o;

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
  );
endinterface

// File: rtl/riscv_imem_rsp_pipe.sv
// MEM_LATENCY-deep shift register carrying {valid, err} alongside the SRAM read.
module riscv_imem_rsp_pipe
  import riscv_imem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  imem_rsp_t rsp_i,
  output imem_rsp_t rsp_o
);

  imem_rsp_t stage_q [MEM_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= rsp_i;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign rsp_o = stage_q[MEM_LATENCY-1];

endmodule

// File: rtl/riscv_instr_mem_responder.sv
// Instruction-memory responder: grants fetches, reads the SRAM, returns data in order.
// Optional macro RISCV_IMEM_RAND_STALL_EN adds LFSR-driven pseudo-random grant stalls.
module riscv_instr_mem_responder
  import riscv_imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned RDATA_WIDTH     = 32,
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  riscv_instr_mem_responder_if.slave                   bus,
  input  logic                                         load_req_i,
  input  logic [31:0]                                  load_addr_i,
  input  logic [RDATA_WIDTH-1:0]                       load_wdata_i,
  input  logic [RDATA_WIDTH/8-1:0]                     load_be_i,
  output logic                                         load_gnt_o,
  output logic                                         mem_en_o,
  output logic                                         mem_we_o,
  output logic [ADDR_WIDTH-$clog2(RDATA_WIDTH/8)-1:0]  mem_addr_o,
  output logic [RDATA_WIDTH-1:0]                       mem_wdata_o,
  output logic [RDATA_WIDTH/8-1:0]                     mem_be_o,
  input  logic [RDATA_WIDTH-1:0]                       mem_rdata_i
);

  localparam int unsigned OFFS  = $clog2(RDATA_WIDTH/8);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);

  if (!(RDATA_WIDTH == 32 || RDATA_WIDTH == 128)) begin : g_bad_width
    $error("RDATA_WIDTH must be 32 or 128");
  end
  if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_lat
    $error("MEM_LATENCY out of range");
  end
  if (MAX_OUTSTANDING < MAX_OUTSTANDING_MIN || MAX_OUTSTANDING > MAX_OUTSTANDING_MAX) begin : g_bad_out
    $error("MAX_OUTSTANDING out of range");
  end

  logic stall;
`ifdef RISCV_IMEM_RAND_STALL_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  assign lfsr_d = lfsr_next(lfsr_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  logic             load_oor, fetch_oor, gnt, retire, room;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  imem_rsp_t        rsp_in, rsp_out;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{load_addr_i[OFFS-1:0], bus.instr_addr_i[OFFS-1:0]};

  assign load_oor  = |(load_addr_i >> ADDR_WIDTH);
  assign fetch_oor = |(bus.instr_addr_i >> ADDR_WIDTH);

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign retire = rsp_out.valid;
  assign room   = (int'(cnt_q) - int'(retire)) < int'(MAX_OUTSTANDING);
  assign gnt    = ~rst & bus.instr_req_i & ~load_req_i & ~stall & room;

  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !retire)      cnt_d = cnt_q + CNT_W'(1);
    else if (!gnt && retire) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (!rst && load_req_i) begin
      if (!load_oor) begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = load_addr_i[ADDR_WIDTH-1:OFFS];
        mem_wdata_o = load_wdata_i;
        mem_be_o    = load_be_i;
      end
    end else if (gnt && !fetch_oor) begin
      mem_en_o   = 1'b1;
      mem_addr_o = bus.instr_addr_i[ADDR_WIDTH-1:OFFS];
    end
  end

  assign rsp_in = '{valid: gnt, err: gnt & fetch_oor};

  riscv_imem_rsp_pipe #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_rsp_pipe (
    .clk   (clk),
    .rst   (rst),
    .rsp_i (rsp_in),
    .rsp_o (rsp_out)
  );

  assign load_gnt_o         = ~rst & load_req_i;
  assign bus.instr_gnt_o    = gnt;
  assign bus.instr_rvalid_o = rsp_out.valid;
  assign bus.instr_err_o    = rsp_out.valid & rsp_out.err;
  assign bus.instr_rdata_o  = (rsp_out.valid && !rsp_out.err) ? mem_rdata_i : '0;

  a_no_gnt_during_load: assert property (@(posedge clk) disable iff (rst)
    !(bus.instr_gnt_o && load_req_i));
  a_rvalid_has_grant: assert property (@(posedge clk) disable iff (rst)
    bus.instr_rvalid_o |-> (cnt_q != '0));

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Directed bench: default instance (latency 1) and a latency-3 / 2-outstanding instance.
module tb_riscv_instr_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  riscv_instr_mem_responder_if #(.RDATA_WIDTH(32)) bus1 ();
  riscv_instr_mem_responder_if #(.RDATA_WIDTH(32)) bus3 ();

  logic        ld1_req, ld1_gnt;
  logic [31:0] ld1_addr, ld1_wdata;
  logic [3:0]  ld1_be;
  logic        m1_en, m1_we;
  logic [13:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [3:0]  m1_be;

  logic        ld3_req, ld3_gnt;
  logic [31:0] ld3_addr, ld3_wdata;
  logic [3:0]  ld3_be;
  logic        m3_en, m3_we;
  logic [13:0] m3_addr;
  logic [31:0] m3_wdata, m3_rdata;
  logic [3:0]  m3_be;

  assign ld3_req   = 1'b0;
  assign ld3_addr  = '0;
  assign ld3_wdata = '0;
  assign ld3_be    = '0;

  riscv_instr_mem_responder dut (
    .clk(clk), .rst(rst), .bus(bus1),
    .load_req_i(ld1_req), .load_addr_i(ld1_addr), .load_wdata_i(ld1_wdata), .load_be_i(ld1_be),
    .load_gnt_o(ld1_gnt), .mem_en_o(m1_en), .mem_we_o(m1_we), .mem_addr_o(m1_addr),
    .mem_wdata_o(m1_wdata), .mem_be_o(m1_be), .mem_rdata_i(m1_rdata)
  );

  riscv_instr_mem_responder #(.MEM_LATENCY(3), .MAX_OUTSTANDING(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .load_req_i(ld3_req), .load_addr_i(ld3_addr), .load_wdata_i(ld3_wdata), .load_be_i(ld3_be),
    .load_gnt_o(ld3_gnt), .mem_en_o(m3_en), .mem_we_o(m3_we), .mem_addr_o(m3_addr),
    .mem_wdata_o(m3_wdata), .mem_be_o(m3_be), .mem_rdata_i(m3_rdata)
  );

  // SRAM models: unwritten words read back as a fixed pattern of their index.
  bit [31:0] mem1 [16384];
  bit        wr1  [16384];
  bit [31:0] cur1;
  initial m1_rdata = '0;
  always @(posedge clk) begin
    if (m1_en) begin
      cur1 = wr1[m1_addr] ? mem1[m1_addr] : (32'h1000_0000 + 32'(m1_addr));
      if (m1_we) begin
        for (int b = 0; b < 4; b++)
          if (m1_be[b]) cur1[8*b +: 8] = m1_wdata[8*b +: 8];
        mem1[m1_addr] = cur1;
        wr1[m1_addr]  = 1'b1;
      end else begin
        m1_rdata <= cur1;
      end
    end
  end

  logic [31:0] r3a = '0, r3b = '0;
  initial m3_rdata = '0;
  always @(posedge clk) begin
    if (m3_en && !m3_we) r3a <= 32'h3000_0000 + 32'(m3_addr);
    r3b      <= r3a;
    m3_rdata <= r3b;
  end

  task automatic test_reset();
    bus1.instr_req_i = 1'b1; bus1.instr_addr_i = 32'h0;
    bus3.instr_req_i = 1'b1; bus3.instr_addr_i = 32'h0;
    ld1_req = 1'b1; ld1_addr = 32'h10; ld1_wdata = 32'h1234_5678; ld1_be = 4'hF;
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus1.instr_gnt_o, bus1.instr_rvalid_o, bus1.instr_err_o, ld1_gnt, m1_en, m1_we} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl1: got gnt/rv/err/lgnt/en/we=%b want 000000",
               {bus1.instr_gnt_o, bus1.instr_rvalid_o, bus1.instr_err_o, ld1_gnt, m1_en, m1_we});
    end
    n_cmp++;
    if ({m1_addr, m1_wdata, m1_be, bus1.instr_rdata_o} !== 82'b0) begin
      n_bad++;
      $display("FAIL reset_data1: got addr=%h wdata=%h be=%h rdata=%h want all 0",
               m1_addr, m1_wdata, m1_be, bus1.instr_rdata_o);
    end
    n_cmp++;
    if ({bus3.instr_gnt_o, bus3.instr_rvalid_o, bus3.instr_err_o, m3_en} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl3: got gnt/rv/err/en=%b want 0000",
               {bus3.instr_gnt_o, bus3.instr_rvalid_o, bus3.instr_err_o, m3_en});
    end
    bus1.instr_req_i = 1'b0; bus3.instr_req_i = 1'b0; ld1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_stream();
    bit [3:0] eg  = 4'b0111;
    bit [3:0] erv = 4'b1110;
    int unsigned k = 0;
    for (int c = 0; c < 4; c++) begin
      bus1.instr_req_i  = (c < 3);
      bus1.instr_addr_i = 32'(c * 4);
      @(negedge clk);
      n_cmp++;
      if ({bus1.instr_gnt_o, bus1.instr_rvalid_o, bus1.instr_err_o} !== {eg[c], erv[c], 1'b0}) begin
        n_bad++;
        $display("FAIL fetch_stream_hs c%0d: got gnt/rv/err=%b want %b", c,
                 {bus1.instr_gnt_o, bus1.instr_rvalid_o, bus1.instr_err_o}, {eg[c], erv[c], 1'b0});
      end
      if (eg[c]) begin
        n_cmp++;
        if ({m1_en, m1_we, m1_addr} !== {2'b10, 14'(c)}) begin
          n_bad++;
          $display("FAIL fetch_stream_mem c%0d: got en/we/addr=%b/%b/%h want 1/0/%h",
                   c, m1_en, m1_we, m1_addr, 14'(c));
        end
      end
      if (erv[c]) begin
        n_cmp++;
        if (bus1.instr_rdata_o !== 32'h1000_0000 + k) begin
          n_bad++;
          $display("FAIL fetch_stream_rdata c%0d: got %h want %h", c, bus1.instr_rdata_o, 32'h1000_0000 + k);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    bus1.instr_req_i = 1'b0;
  endtask

  task automatic test_outstanding();
    bit [9:0] eg  = 10'b0001011011;
    bit [9:0] erv = 10'b1011011000;
    int unsigned idx = 0, k = 0;
    int occ = 0, max_occ = 0;
    for (int c = 0; c < 10; c++) begin
      bus3.instr_req_i  = (c < 7);
      bus3.instr_addr_i = 32'(idx * 4);
      @(negedge clk);
      n_cmp++;
      if ({bus3.instr_gnt_o, bus3.instr_rvalid_o} !== {eg[c], erv[c]}) begin
        n_bad++;
        $display("FAIL outstanding_hs c%0d: got gnt/rv=%b want %b", c,
                 {bus3.instr_gnt_o, bus3.instr_rvalid_o}, {eg[c], erv[c]});
      end
      if (erv[c]) begin
        n_cmp++;
        if (bus3.instr_rdata_o !== 32'h3000_0000 + k) begin
          n_bad++;
          $display("FAIL outstanding_rdata c%0d: got %h want %h", c, bus3.instr_rdata_o, 32'h3000_0000 + k);
        end
        k++;
      end
      occ = occ + int'(bus3.instr_gnt_o) - int'(bus3.instr_rvalid_o);
      if (occ > max_occ) max_occ = occ;
      if (eg[c]) idx++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (max_occ != 2) begin
      n_bad++;
      $display("FAIL outstanding_max: got peak %0d want 2", max_occ);
    end
  endtask

  task automatic test_load_hazard();
    ld1_req = 1'b1; ld1_addr = 32'h10; ld1_wdata = 32'hDEAD_BEEF; ld1_be = 4'hF;
    bus1.instr_req_i = 1'b1; bus1.instr_addr_i = 32'h10;
    @(negedge clk);
    n_cmp++;
    if ({ld1_gnt, bus1.instr_gnt_o, m1_en, m1_we, m1_addr} !== {4'b1011, 14'h4}) begin
      n_bad++;
      $display("FAIL load_write: got lgnt/gnt/en/we=%b addr=%h want 1011 addr=4",
               {ld1_gnt, bus1.instr_gnt_o, m1_en, m1_we}, m1_addr);
    end
    @(posedge clk); #1;
    ld1_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus1.instr_gnt_o, m1_en, m1_we, m1_addr} !== {3'b110, 14'h4}) begin
      n_bad++;
      $display("FAIL load_fetch: got gnt/en/we=%b addr=%h want 110 addr=4",
               {bus1.instr_gnt_o, m1_en, m1_we}, m1_addr);
    end
    @(posedge clk); #1;
    bus1.instr_req_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus1.instr_rvalid_o, bus1.instr_err_o, bus1.instr_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL load_readback: got rv/err=%b rdata=%h want 10 rdata=deadbeef",
               {bus1.instr_rvalid_o, bus1.instr_err_o}, bus1.instr_rdata_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_block();
    bit [7:0] eg  = 8'b01100011;
    bit [7:0] erv = 8'b11000110;
    int unsigned idx = 0, k = 0;
    for (int c = 0; c < 8; c++) begin
      bus1.instr_req_i  = (c < 7);
      bus1.instr_addr_i = 32'h40 + 32'(idx * 4);
      ld1_req   = (c >= 2 && c <= 4);
      ld1_addr  = 32'h100 + 32'(c * 4);
      ld1_wdata = 32'hA0A0_0000 + 32'(c);
      ld1_be    = 4'hF;
      @(negedge clk);
      n_cmp++;
      if ({bus1.instr_gnt_o, bus1.instr_rvalid_o, ld1_gnt} !== {eg[c], erv[c], ld1_req}) begin
        n_bad++;
        $display("FAIL load_block_hs c%0d: got gnt/rv/lgnt=%b want %b", c,
                 {bus1.instr_gnt_o, bus1.instr_rvalid_o, ld1_gnt}, {eg[c], erv[c], ld1_req});
      end
      if (erv[c]) begin
        n_cmp++;
        if (bus1.instr_rdata_o !== 32'h1000_0010 + k) begin
          n_bad++;
          $display("FAIL load_block_rdata c%0d: got %h want %h", c, bus1.instr_rdata_o, 32'h1000_0010 + k);
        end
        k++;
      end
      if (eg[c]) idx++;
      @(posedge clk); #1;
    end
    ld1_req = 1'b0;
    bus1.instr_req_i = 1'b0;
  endtask

  task automatic test_out_of_range();
    bus1.instr_req_i = 1'b1; bus1.instr_addr_i = 32'h0001_0000;
    @(negedge clk);
    n_cmp++;
    if ({bus1.instr_gnt_o, m1_en} !== 2'b10) begin
      n_bad++;
      $display("FAIL oor_fetch_gnt: got gnt/en=%b want 10", {bus1.instr_gnt_o, m1_en});
    end
    @(posedge clk); #1;
    bus1.instr_req_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus1.instr_rvalid_o, bus1.instr_err_o, bus1.instr_rdata_o} !== {2'b11, 32'h0}) begin
      n_bad++;
      $display("FAIL oor_fetch_rsp: got rv/err=%b rdata=%h want 11 rdata=0",
               {bus1.instr_rvalid_o, bus1.instr_err_o}, bus1.instr_rdata_o);
    end
    @(posedge clk); #1;
    ld1_req = 1'b1; ld1_addr = 32'h0002_0000; ld1_wdata = 32'h5555_AAAA; ld1_be = 4'hF;
    @(negedge clk);
    n_cmp++;
    if ({ld1_gnt, m1_en, m1_we} !== 3'b100) begin
      n_bad++;
      $display("FAIL oor_load: got lgnt/en/we=%b want 100", {ld1_gnt, m1_en, m1_we});
    end
    @(posedge clk); #1;
    ld1_req = 1'b0;
  endtask

  task automatic test_reset_inflight();
    for (int c = 0; c < 2; c++) begin
      bus3.instr_req_i = 1'b1; bus3.instr_addr_i = 32'(c * 4);
      @(negedge clk);
      n_cmp++;
      if (bus3.instr_gnt_o !== 1'b1) begin
        n_bad++;
        $display("FAIL inflight_gnt c%0d: got %b want 1", c, bus3.instr_gnt_o);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int c = 2; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus3.instr_gnt_o, bus3.instr_rvalid_o, bus3.instr_err_o, bus3.instr_rdata_o, m3_en} !== 36'b0) begin
        n_bad++;
        $display("FAIL inflight_held c%0d: got gnt/rv/err=%b rdata=%h en=%b want all 0", c,
                 {bus3.instr_gnt_o, bus3.instr_rvalid_o, bus3.instr_err_o}, bus3.instr_rdata_o, m3_en);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus3.instr_req_i = 1'b0;
    for (int c = 4; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus3.instr_rvalid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL inflight_drop c%0d: got rvalid %b want 0", c, bus3.instr_rvalid_o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at time limit, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus1.instr_req_i = 1'b0; bus1.instr_addr_i = '0;
    bus3.instr_req_i = 1'b0; bus3.instr_addr_i = '0;
    ld1_req = 1'b0; ld1_addr = '0; ld1_wdata = '0; ld1_be = '0;
    test_reset();
    test_fetch_stream();
    test_outstanding();
    test_load_hazard();
    test_load_block();
    test_out_of_range();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_instr_mem_responder.md
# riscv_instr_mem_responder

Instruction-memory responder for the RI5CY fetch interface. It answers the core's `instr_req/gnt/rvalid` protocol by granting requests, reading a single-port synchronous SRAM with fixed read latency, and returning read data in order. A boot/debug load port can write the SRAM and takes priority over fetches. It sits between the core's instruction port and the instruction SRAM macro.

## Interface
- `ADDR_WIDTH`, default 16: byte-address bits decoded; memory size is 2^ADDR_WIDTH bytes.
- `RDATA_WIDTH`, default 32: fetch and SRAM word width; legal values are 32 or 128.
- `MEM_LATENCY`, default 1: cycles from `mem_en_o` to valid `mem_rdata_i`; legal range 1..4.
- `MAX_OUTSTANDING`, default 2: maximum number of granted reads without a response yet; legal range 1..4.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_req_i`  in  1  fetch request.
- `instr_addr_i`  in  32  fetch byte address.
- `instr_gnt_o`  out  1  request accepted this cycle.
- `instr_rvalid_o`  out  1  read data valid.
- `instr_rdata_o`  out  RDATA_WIDTH  read data.
- `instr_err_o`  out  1  qualifies `instr_rvalid_o`; set for an out-of-range address.
- `load_req_i`  in  1  load write request.
- `load_addr_i`  in  32  load byte address.
- `load_wdata_i`  in  RDATA_WIDTH  load write data.
- `load_be_i`  in  RDATA_WIDTH/8  byte enables.
- `load_gnt_o`  out  1  load accepted.
- `mem_en_o`, `mem_we_o`  out  1  SRAM enable and write enable.
- `mem_addr_o`  out  ADDR_WIDTH-log2(RDATA_WIDTH/8)  SRAM word address.
- `mem_wdata_o`  out  RDATA_WIDTH  SRAM write data.
- `mem_be_o`  out  RDATA_WIDTH/8  SRAM byte enables.
- `mem_rdata_i`  in  RDATA_WIDTH  SRAM read data.

## Operation
**Load port**
- `load_gnt_o = load_req_i`. The load port always wins arbitration.
- An in-range load drives `mem_en_o=1`, `mem_we_o=1`, and word address `load_addr_i[ADDR_WIDTH-1:log2(RDATA_WIDTH/8)]`.
- An out-of-range load (any of `load_addr_i[31:ADDR_WIDTH]` set) is granted and dropped: no SRAM access.

**Fetch grant and read**
- `instr_gnt_o = instr_req_i & ~load_req_i & ~stall & (outstanding_q - retire < MAX_OUTSTANDING)`.
  - `retire` is `instr_rvalid_o` in the same cycle.
  - The grant is combinational in the request cycle.
- An in-range granted fetch drives `mem_en_o=1`, `mem_we_o=0`, and the word address.
- An out-of-range fetch gets no SRAM access. Its response is `instr_err_o=1` with `instr_rdata_o='0`.

**Response pipeline**
- The pipeline is a shift register `MEM_LATENCY` deep, carrying `{valid, err}`.
- `instr_rvalid_o` asserts exactly `MEM_LATENCY` cycles after the grant.
- `instr_rdata_o = err ? '0 : mem_rdata_i`.
- Responses return in grant order. There is no backpressure, so every grant produces exactly one rvalid.

**Outstanding counter**
- Width is `$clog2(MAX_OUTSTANDING+1)`.
- +1 on grant, −1 on rvalid, unchanged when both occur in the same cycle.
- Never exceeds `MAX_OUTSTANDING` and never underflows.

**Ordering and hazards**
- A write in cycle N followed by a read of the same word granted in cycle N+1 or later returns the new data.
- Reads already launched are unaffected by later writes.

**Reset**
- `rst` clears the pipeline and counter. Responses in flight are discarded and never signalled.
- All outputs reset to 0: gnt, rvalid, err, rdata, load_gnt, and all `mem_*` signals.

## Timing
- Grant latency: 0 cycles. Response latency: `MEM_LATENCY` cycles after the grant.
- Throughput is one fetch per cycle when `MAX_OUTSTANDING ≥ MEM_LATENCY` and there is no load or stall. Otherwise a grant is blocked until a retire.
- `instr_rvalid_o`, `instr_err_o` and `instr_rdata_o` are registered from the pipeline, except that rdata passes `mem_rdata_i` through.
- A `load_req_i` held for K cycles blocks fetch grants for exactly K cycles. Responses for fetches already granted still return on schedule.

## Configuration
- Macro `RISCV_IMEM_RAND_STALL_EN`.
  - **Defined:** an 8-bit Fibonacci LFSR is built in.
    - Taps x^8+x^6+x^5+x^4+1, seed `8'hA5` on reset, advancing every cycle.
    - `stall = (lfsr[1:0] == 2'b00)` inserts pseudo-random grant wait states.
  - **Undefined:** `stall = 0` and no LFSR exists.

## Structure
- Shared package `riscv_imem_pkg` holds:
  - the LFSR seed and taps constants;
  - the `imem_rsp_t` struct `{valid, err}`;
  - the legal-range constants for `MEM_LATENCY` and `MAX_OUTSTANDING`.
- One sub-module, `riscv_imem_rsp_pipe`: a parameterised `MEM_LATENCY`-stage shift register of `imem_rsp_t` with an async-high reset.
- Elaboration assertions check `RDATA_WIDTH ∈ {32,128}` and the legal parameter ranges.
- Simulation assertions:
  - no rvalid without a prior grant;
  - `instr_gnt_o` never asserts while `load_req_i` is high.

## Test plan
- Defaults, macro undefined. `instr_req_i` held high with addresses 0x0, 0x4, 0x8 → gnt in cycles 0, 1, 2; rvalid in cycles 1, 2, 3 carrying the SRAM words 0, 1, 2.
- `MEM_LATENCY=3`, `MAX_OUTSTANDING=2`, continuous requests → grants in cycles 0 and 1; a third grant waits for the first rvalid in cycle 3; counter never exceeds 2.
- Load 0xDEADBEEF to 0x10 in cycle 0, fetch 0x10 in cycle 1 → rvalid in cycle 2 with rdata 0xDEADBEEF.
- `load_req_i` high for cycles 2–4 during a fetch stream → `instr_gnt_o` low in cycles 2–4; responses for cycles 0–1 still arrive.
- Fetch of 0x0001_0000 with `ADDR_WIDTH=16` → gnt, no `mem_en_o`; rvalid with `instr_err_o=1` and rdata 0.
- Assert `rst` with two reads in flight → no rvalid afterwards; all outputs 0 while reset is held.
